fc_ibuf_stream: RTL

FC_IBUF_STREAM -- requirements
Module: fc_ibuf_stream

---
 rtl/fc_ibuf_stream.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fc_ibuf_stream.sv
// Activation input buffer: fills element vectors beat by beat, then presents them
// one bit-plane at a time (LSB first) as BUS_WIDTH-bit words selected by i_addr.
module fc_ibuf_stream #(
   parameter int DATA_SIZE    = 8,
   parameter int NUM_CHANNELS = 2,
   parameter int FIFO_LENGTH  = 16,
   parameter int BUS_WIDTH    = 16,
   localparam int ELEMS    = NUM_CHANNELS * FIFO_LENGTH,
   localparam int NUM_ADDR = (ELEMS + BUS_WIDTH - 1) / BUS_WIDTH,
   localparam int ADDR_W   = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
   localparam int BIT_W    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_valid,
   input  logic                                   i_last,
   input  logic [NUM_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
   output logic                                   o_ready,
   input  logic                                   i_next,
   input  logic                                   i_flush,
   input  logic [ADDR_W-1:0]                      i_addr,
   output logic [BUS_WIDTH-1:0]                   o_data,
   output logic                                   o_plane_valid,
   output logic [BIT_W-1:0]                       o_bit_idx,
   output logic                                   o_last_plane
);

   localparam int BEAT_W = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1;

   typedef enum logic [0:0] {
      S_FILL  = 1'b0,
      S_PLANE = 1'b1
   } state_t;

   state_t                      state_q, state_d;
   logic [BEAT_W-1:0]           beat_q, beat_d;
   logic [BIT_W-1:0]            bit_idx_q, bit_idx_d;
   logic [DATA_SIZE-1:0]        elem_q [ELEMS];
   logic [DATA_SIZE-1:0]        elem_d [ELEMS];
   logic [BUS_WIDTH-1:0]        data_q;
   logic                        ready_q;
   logic                        plane_valid_q;
   logic                        last_plane_q;
   logic                        accept_s;
   logic                        beat_end_s;
   logic                        plane_end_s;
   logic [NUM_ADDR*BUS_WIDTH-1:0] plane_s;
   logic [BUS_WIDTH-1:0]        word_s;

   // Next-state logic; every entry into FILL clears the elements so a short vector
   // arrives in PLANE with its unwritten tail already zero.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      bit_idx_d   = bit_idx_q;
      for (int e = 0; e < ELEMS; e++) begin
         elem_d[e] = elem_q[e];
      end
      accept_s    = (state_q == S_FILL) && i_valid;
      beat_end_s  = i_last || (beat_q == BEAT_W'(FIFO_LENGTH - 1));
      plane_end_s = (bit_idx_q == BIT_W'(DATA_SIZE - 1));

      if (i_flush) begin
         state_d   = S_FILL;
         beat_d    = '0;
         bit_idx_d = '0;
         for (int e = 0; e < ELEMS; e++) begin
            elem_d[e] = '0;
         end
      end else begin
         case (state_q)
            S_FILL: begin
               if (accept_s) begin
                  for (int w = 0; w < FIFO_LENGTH; w++) begin
                     for (int j = 0; j < NUM_CHANNELS; j++) begin
                        elem_d[w*NUM_CHANNELS + j] = (beat_q == BEAT_W'(w)) ?
                           i_data[j] : elem_q[w*NUM_CHANNELS + j];
                     end
                  end
                  if (beat_end_s) begin
                     state_d = S_PLANE;
                     beat_d  = '0;
                  end else begin
                     beat_d  = beat_q + BEAT_W'(1);
                  end
               end else begin
                  beat_d = beat_q;
               end
            end
            S_PLANE: begin
               if (i_next) begin
                  if (plane_end_s) begin
                     state_d   = S_FILL;
                     beat_d    = '0;
                     bit_idx_d = '0;
                     for (int e = 0; e < ELEMS; e++) begin
                        elem_d[e] = '0;
                     end
                  end else begin
                     bit_idx_d = bit_idx_q + BIT_W'(1);
                     for (int e = 0; e < ELEMS; e++) begin
                        elem_d[e] = elem_q[e] >> 1;
                     end
                  end
               end else begin
                  state_d = S_PLANE;
               end
            end
            default: begin
               state_d   = S_FILL;
               beat_d    = '0;
               bit_idx_d = '0;
               for (int e = 0; e < ELEMS; e++) begin
                  elem_d[e] = '0;
               end
            end
         endcase
      end
   end

   // Word select from the plane that will be presented after this edge.
   always_comb begin
      plane_s = '0;
      for (int e = 0; e < ELEMS; e++) begin
         plane_s[e] = elem_d[e][0];
      end
      word_s = '0;
      for (int a = 0; a < NUM_ADDR; a++) begin
         word_s = (i_addr == ADDR_W'(a)) ? plane_s[a*BUS_WIDTH +: BUS_WIDTH] : word_s;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_FILL;
         beat_q        <= '0;
         bit_idx_q     <= '0;
         for (int e = 0; e < ELEMS; e++) begin
            elem_q[e] <= '0;
         end
         data_q        <= '0;
         ready_q       <= 1'b1;
         plane_valid_q <= 1'b0;
         last_plane_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         bit_idx_q     <= bit_idx_d;
         for (int e = 0; e < ELEMS; e++) begin
            elem_q[e] <= elem_d[e];
         end
         data_q        <= (state_d == S_PLANE) ? word_s : '0;
         ready_q       <= (state_d == S_FILL);
         plane_valid_q <= (state_d == S_PLANE);
         last_plane_q  <= (state_d == S_PLANE) && (bit_idx_d == BIT_W'(DATA_SIZE - 1));
      end
   end

   assign o_ready       = ready_q;
   assign o_plane_valid = plane_valid_q;
   assign o_bit_idx     = bit_idx_q;
   assign o_last_plane  = last_plane_q;
   assign o_data        = data_q;

endmodule
